dual_slope_ctrl: RTL and testbench

Parametrised dual-slope ADC sequencer with an on-board count register, N_CH-way input multiplexing and an auto-zero phase. It drives the analog switch bank: one input switch per channel, a reference switch and a zero switch. It times the fixed integrate phase and the variable de-integrate phase, then latches the conversion result with a one-cycle done pulse. It sits between the integrator/comparator front end and the digital readout logic.

---
 rtl/dual_slope_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_ctrl.sv
// ---------------------------------------------------------------------------
// dual_slope_ctrl
//
// Sequencer for a dual-slope ADC with N_CH multiplexed inputs and an
// auto-zero phase. One conversion runs IDLE -> AUTOZERO -> INTEG -> DEINT ->
// DONE -> IDLE and drives the analog switch bank so that exactly one of the
// input switches, the reference switch or the zero switch is closed at any
// time.
//
// Parameters
//   N_BITS     result/counter width; the integrate phase lasts 2^N_BITS cycles
//   N_CH       number of analog input channels (>= 2)
//   AZ_CYCLES  auto-zero phase length in clock cycles (>= 1)
//   CH_W       channel index width (derived from N_CH)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset (aborts a running conversion)
//   iniciar    start request, honoured in IDLE only
//   ch_sel     channel to convert, latched together with iniciar
//   vint_z     comparator: integrator output at/below zero
//   sw_in      one-hot input switch enables (INTEG)
//   sw_ref     reference switch enable (DEINT)
//   sw_zr      zero/discharge switch enable (IDLE, AUTOZERO, DONE)
//   busy       conversion in progress (AUTOZERO..DEINT)
//   done       one-cycle pulse, resultado/ch_out/overrange valid
//   resultado  last conversion count
//   ch_out     channel that produced resultado
//   overrange  last conversion saturated without a comparator trip
// ---------------------------------------------------------------------------
module dual_slope_ctrl #(
    parameter int N_BITS    = 8,
    parameter int N_CH      = 4,
    parameter int AZ_CYCLES = 16,
    parameter int CH_W      = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              vint_z,
    output logic [N_CH-1:0]   sw_in,
    output logic              sw_ref,
    output logic              sw_zr,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] resultado,
    output logic [CH_W-1:0]   ch_out,
    output logic              overrange
);

    localparam int                AZ_W    = (AZ_CYCLES > 1) ? $clog2(AZ_CYCLES) : 1;
    localparam logic [AZ_W-1:0]   AZ_LAST = AZ_W'(AZ_CYCLES - 1);
    localparam logic [N_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        AUTOZERO,
        INTEG,
        DEINT,
        DONE
    } state_t;

    state_t state, state_d;

    logic [N_BITS-1:0] counter;
    logic [AZ_W-1:0]   az_cnt;
    logic [CH_W-1:0]   ch_lat;
    logic              ch_ok;
    logic              start_ok;

    // Registered-output inputs (decoded from the next state)
    logic [N_CH-1:0]   sw_in_d;
    logic              sw_ref_d;
    logic              sw_zr_d;
    logic              busy_d;
    logic              done_d;

    // Out-of-range channel requests are dropped. The extra bit keeps the
    // compare meaningful when N_CH is an exact power of two.
    assign ch_ok    = ({1'b0, ch_sel} < (CH_W + 1)'(N_CH));
    assign start_ok = (state == IDLE) && iniciar && ch_ok;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_d = AUTOZERO;
                end
            end
            AUTOZERO: begin
                if (az_cnt == AZ_LAST) begin
                    state_d = INTEG;
                end
            end
            INTEG: begin
                if (counter == CNT_MAX) begin
                    state_d = DEINT;
                end
            end
            DEINT: begin
                if (vint_z || (counter == CNT_MAX)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. Outputs are decoded from the next state and registered,
    // so every output changes in the same cycle as the state register while
    // still coming straight from a flop.
    // -----------------------------------------------------------------------
    always_comb begin
        sw_in_d  = '0;
        sw_ref_d = 1'b0;
        sw_zr_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            IDLE: begin
                sw_zr_d = 1'b1;
            end
            AUTOZERO: begin
                sw_zr_d = 1'b1;
                busy_d  = 1'b1;
            end
            INTEG: begin
                busy_d = 1'b1;
                // ch_lat is already stable on entry to INTEG
                for (int unsigned i = 0; i < N_CH; i++) begin
                    sw_in_d[i] = (ch_lat == CH_W'(i));
                end
            end
            DEINT: begin
                sw_ref_d = 1'b1;
                busy_d   = 1'b1;
            end
            DONE: begin
                sw_zr_d = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                sw_zr_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_in  <= '0;
            sw_ref <= 1'b0;
            sw_zr  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            sw_in  <= sw_in_d;
            sw_ref <= sw_ref_d;
            sw_zr  <= sw_zr_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: phase timers, channel latch and result registers.
    // resultado/ch_out/overrange are written on the DEINT -> DONE transition
    // so they are already valid while done is high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            az_cnt    <= '0;
            ch_lat    <= '0;
            resultado <= '0;
            ch_out    <= '0;
            overrange <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        ch_lat  <= ch_sel;
                        counter <= '0;
                        az_cnt  <= '0;
                    end
                end
                AUTOZERO: begin
                    az_cnt <= az_cnt + 1'b1;
                    if (az_cnt == AZ_LAST) begin
                        counter <= '0;
                    end
                end
                INTEG: begin
                    // Wraps from all-ones to zero on the last integrate cycle,
                    // which is exactly the DEINT starting count.
                    counter <= counter + 1'b1;
                end
                DEINT: begin
                    if (vint_z) begin
                        resultado <= counter;
                        overrange <= 1'b0;
                        ch_out    <= ch_lat;
                    end else if (counter == CNT_MAX) begin
                        resultado <= '1;
                        overrange <= 1'b1;
                        ch_out    <= ch_lat;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dual_slope_ctrl
//
// Directed bench for dual_slope_ctrl with N_BITS=4, N_CH=4, AZ_CYCLES=4.
// Expected conversion results (count, channel, overrange, done cycle) are
// queued when a conversion is launched and compared when done appears.
// ---------------------------------------------------------------------------
module tb_dual_slope_ctrl;

    localparam int N_BITS    = 4;
    localparam int N_CH      = 4;
    localparam int AZ_CYCLES = 4;
    localparam int CH_W      = 2;
    localparam int INT_LEN   = 1 << N_BITS;            // 16
    localparam int DE_OFS    = 1 + AZ_CYCLES + INT_LEN; // first DEINT cycle after t

    logic              clk;
    logic              reset;
    logic              iniciar;
    logic [CH_W-1:0]   ch_sel;
    logic              vint_z;
    logic [N_CH-1:0]   sw_in;
    logic              sw_ref;
    logic              sw_zr;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] resultado;
    logic [CH_W-1:0]   ch_out;
    logic              overrange;

    dual_slope_ctrl #(
        .N_BITS   (N_BITS),
        .N_CH     (N_CH),
        .AZ_CYCLES(AZ_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iniciar  (iniciar),
        .ch_sel   (ch_sel),
        .vint_z   (vint_z),
        .sw_in    (sw_in),
        .sw_ref   (sw_ref),
        .sw_zr    (sw_zr),
        .busy     (busy),
        .done     (done),
        .resultado(resultado),
        .ch_out   (ch_out),
        .overrange(overrange)
    );

    typedef struct {
        int res;
        int ch;
        int ovr;
        int cyc;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int passed   = 0;
    int cyc      = 0;
    bit inv_en   = 1'b0;
    int last_res = 0;
    int last_ovr = 0;
    int last_ch  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value of cyc between two rising edges
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Switch invariant and scoreboard compare on every falling edge
    always @(negedge clk) begin
        if (inv_en) begin
            check("switch_onehot", $countones({sw_in, sw_ref, sw_zr}), 1);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("resultado", resultado, e.res);
                    check("ch_out", ch_out, e.ch);
                    check("overrange", overrange, e.ovr);
                end
            end
        end
    end

    // One conversion starting in the current cycle t. k is the DEINT cycle
    // in which vint_z first rises (k < 0: never). noise adds ignored
    // iniciar pulses in INTEG/DEINT and an early vint_z burst in INTEG.
    task automatic run_conv(input int ch, input int k, input bit noise);
        int   t;
        int   end_m;
        exp_t e;
        t       = cyc;
        end_m   = (k >= 0) ? DE_OFS + 1 + k : DE_OFS + INT_LEN;
        e.res   = (k >= 0) ? k : INT_LEN - 1;
        e.ovr   = (k >= 0) ? 0 : 1;
        e.ch    = ch;
        e.cyc   = t + end_m;
        sb.push_back(e);
        iniciar = 1'b1;
        ch_sel  = CH_W'(ch);
        for (int m = 1; m <= end_m; m++) begin
            @(negedge clk);
            iniciar = 1'b0;
            vint_z  = 1'b0;
            if (m == 1) begin
                check("hold_resultado", resultado, last_res);
                check("hold_overrange", overrange, last_ovr);
                check("hold_ch_out", ch_out, last_ch);
            end
            if (m <= AZ_CYCLES) begin
                check("az_sw_zr", sw_zr, 1);
                check("az_busy", busy, 1);
            end else if (m < DE_OFS) begin
                check("integ_sw_in", sw_in, 1 << ch);
                check("integ_busy", busy, 1);
                if (noise && m >= 8 && m <= 12) vint_z = 1'b1;
                if (noise && m == 10) begin
                    iniciar = 1'b1;
                    ch_sel  = CH_W'((ch + 1) % N_CH);
                end
            end else if (m < end_m) begin
                check("deint_sw_ref", sw_ref, 1);
                check("deint_busy", busy, 1);
                check("deint_no_done", done, 0);
                if (k >= 0 && (m - DE_OFS) >= k) vint_z = 1'b1;
                if (noise && (m - DE_OFS) == 2) begin
                    iniciar = 1'b1;
                    ch_sel  = CH_W'((ch + 2) % N_CH);
                end
            end else begin
                check("done_sw_zr", sw_zr, 1);
                check("done_busy", busy, 0);
                // Request during DONE must be ignored
                iniciar = 1'b1;
                ch_sel  = CH_W'(ch);
            end
        end
        @(negedge clk);
        iniciar = 1'b0;
        check("after_done_busy", busy, 0);
        check("after_done_done", done, 0);
        check("after_done_sw_zr", sw_zr, 1);
        last_res = e.res;
        last_ovr = e.ovr;
        last_ch  = e.ch;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        ch_sel  = '0;
        vint_z  = 1'b0;

        // Reset held over two rising edges
        @(negedge clk);
        inv_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_sw_zr", sw_zr, 1);
        check("rst_sw_in", sw_in, 0);
        check("rst_sw_ref", sw_ref, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resultado", resultado, 0);
        check("rst_overrange", overrange, 0);
        check("rst_ch_out", ch_out, 0);

        // Nominal conversion with ignored requests and early vint_z
        run_conv(2, 5, 1'b1);
        // Saturation without comparator trip
        run_conv(1, -1, 1'b0);
        // Comparator trips on the saturation count: vint_z wins
        run_conv(1, 15, 1'b0);
        // Highest channel, trip in DEINT cycle 0
        run_conv(3, 0, 1'b1);

        // Reset during DEINT aborts the conversion without a done pulse
        iniciar = 1'b1;
        ch_sel  = CH_W'(0);
        for (int m = 1; m <= DE_OFS + 3; m++) begin
            @(negedge clk);
            iniciar = 1'b0;
        end
        check("pre_abort_sw_ref", sw_ref, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_sw_zr", sw_zr, 1);
        check("abort_sw_in", sw_in, 0);
        check("abort_sw_ref", sw_ref, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_resultado", resultado, 0);
        check("abort_overrange", overrange, 0);
        check("abort_ch_out", ch_out, 0);
        last_res = 0;
        last_ovr = 0;
        last_ch  = 0;
        repeat (3) @(negedge clk);
        check("abort_idle_busy", busy, 0);

        // Fresh conversion after the abort
        run_conv(3, 7, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
